seg_scan_ctrl: RTL

- Time-multiplexes an 8-digit, common-anode seven-segment display.
- Counts out a fixed refresh slot per digit, decodes the active hex nibble, and drives anodes, segments and decimal point.
- Includes an inter-digit blanking window to suppress ghosting.
- Display contents are loaded through a valid/ready port and take effect only at a frame boundary, so a frame never shows a mix of old and new data.

---
 rtl/seg_scan_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit common-anode seven-segment display.
// Loads are double-buffered and take effect only at a frame boundary, or at once while scanning is off.
module seg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 208333,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic [7:0]  wr_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [2:0]  digit_idx,
  output logic        frame_tick
);

  localparam int CW = $clog2(SLOT_CYCLES);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  state_t        state_q, state_d;
  logic          frame_tick_q, frame_tick_d;
  logic [31:0]   pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [7:0]    pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [7:0]    pend_mask_q, pend_mask_d, act_mask_q, act_mask_d;
  logic          pend_full_q, pend_full_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_n_q, dp_n_d;

  logic last_slot, frame_wrap, accept, commit, show;

  always_comb begin
    last_slot  = (cnt_q == CW'(SLOT_CYCLES - 1));
    frame_wrap = en && last_slot && (idx_q == 3'd7);

    cnt_d   = cnt_q;
    idx_d   = idx_q;
    state_d = state_q;
    if (!en) begin
      cnt_d   = '0;
      idx_d   = '0;
      state_d = ST_BLANK;
    end else if (last_slot) begin
      cnt_d   = '0;
      idx_d   = idx_q + 3'd1;
      state_d = ST_BLANK;
    end else begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(BLANK_CYCLES)) state_d = ST_SHOW;
    end
    // Registered so the pulse coincides with the cycle whose end performs the 7->0 wrap.
    frame_tick_d = en && (cnt_d == CW'(SLOT_CYCLES - 1)) && (idx_d == 3'd7);

    accept = wr_valid && !pend_full_q;
    commit = pend_full_q && (en ? frame_wrap : 1'b1);

    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_mask_d = pend_mask_q;
    pend_full_d = pend_full_q;
    if (accept) begin
      pend_data_d = wr_data;
      pend_dp_d   = wr_dp;
      pend_mask_d = wr_mask;
      pend_full_d = 1'b1;
    end else if (commit) begin
      pend_full_d = 1'b0;
    end

    act_data_d = commit ? pend_data_q : act_data_q;
    act_dp_d   = commit ? pend_dp_q   : act_dp_q;
    act_mask_d = commit ? pend_mask_q : act_mask_q;

    // Gating on en here makes the pins go dark on the very next cycle after en drops.
    show   = en && (state_q == ST_SHOW) && act_mask_q[idx_q];
    an_d   = show ? ~(8'h01 << idx_q) : 8'hFF;
    seg_d  = show ? ~hex_to_seg(act_data_q[{idx_q, 2'b00} +: 4]) : 7'h7F;
    dp_n_d = show ? ~act_dp_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= ST_BLANK;
      frame_tick_q <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_mask_q  <= '0;
      pend_full_q  <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_mask_q   <= '0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      frame_tick_q <= frame_tick_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_mask_q  <= pend_mask_d;
      pend_full_q  <= pend_full_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_mask_q   <= act_mask_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
    end
  end

  assign wr_ready   = !pend_full_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign digit_idx  = idx_q;
  assign frame_tick = frame_tick_q;

endmodule
